// File: rtl/register_readback_tx.sv
// ============================================================================
// Module  : register_readback_tx
// Purpose : Framed serial readback of a captured register value
//           (start bit, data LSB first, optional even parity, stop bit).
// Config  : define REGISTER_READBACK_TX_PARITY_EN to insert the parity bit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module register_readback_tx #(
   parameter int WIDTH = 8,
   parameter int DIV   = 4
) (
   input  logic             clock,
   input  logic             input_reset_n,
   input  logic [WIDTH-1:0] input_data,
   input  logic             input_start,
   output logic             output_serial,
   output logic             output_busy,
   output logic             output_done
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef REGISTER_READBACK_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    clk_cnt;
   logic [BW-1:0]    bit_cnt;
`ifdef REGISTER_READBACK_TX_PARITY_EN
   logic             parity;
`endif

   logic bit_end;
   assign bit_end = (clk_cnt == DIV_LAST);

   always_ff @(posedge clock or negedge input_reset_n) begin
      if (!input_reset_n) begin
         state         <= S_IDLE;
         shreg         <= '0;
         clk_cnt       <= '0;
         bit_cnt       <= '0;
         output_serial <= 1'b1;
         output_busy   <= 1'b0;
         output_done   <= 1'b0;
`ifdef REGISTER_READBACK_TX_PARITY_EN
         parity        <= 1'b0;
`endif
      end else begin
         output_done <= 1'b0;
         case (state)
            S_IDLE: begin
               clk_cnt <= '0;
               bit_cnt <= '0;
               if (input_start) begin
                  shreg         <= input_data;
`ifdef REGISTER_READBACK_TX_PARITY_EN
                  parity        <= ^input_data;
`endif
                  state         <= S_START;
                  output_serial <= 1'b0;
                  output_busy   <= 1'b1;
               end
            end
            default: begin
               if (!bit_end) begin
                  clk_cnt <= clk_cnt + CW'(1);
               end else begin
                  clk_cnt <= '0;
                  case (state)
                     // The shift register always holds the next bit to send in bit 0.
                     S_START: begin
                        state         <= S_DATA;
                        output_serial <= shreg[0];
                        shreg         <= shreg >> 1;
                     end
                     S_DATA: begin
                        if (bit_cnt == BIT_LAST) begin
                           bit_cnt       <= '0;
`ifdef REGISTER_READBACK_TX_PARITY_EN
                           state         <= S_PARITY;
                           output_serial <= parity;
`else
                           state         <= S_STOP;
                           output_serial <= 1'b1;
`endif
                        end else begin
                           bit_cnt       <= bit_cnt + BW'(1);
                           output_serial <= shreg[0];
                           shreg         <= shreg >> 1;
                        end
                     end
`ifdef REGISTER_READBACK_TX_PARITY_EN
                     S_PARITY: begin
                        state         <= S_STOP;
                        output_serial <= 1'b1;
                     end
`endif
                     S_STOP: begin
                        state         <= S_IDLE;
                        output_serial <= 1'b1;
                        output_busy   <= 1'b0;
                        output_done   <= 1'b1;
                     end
                     default: begin
                        // Unreachable encodings recover to idle without a done pulse.
                        state         <= S_IDLE;
                        output_serial <= 1'b1;
                        output_busy   <= 1'b0;
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_register_readback_tx.sv
// ============================================================================
// Module  : tb_register_readback_tx
// Purpose : Scoreboard bench for register_readback_tx (WIDTH=8, DIV=4).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_register_readback_tx;

   localparam int WIDTH = 8;
   localparam int DIV   = 4;
`ifdef REGISTER_READBACK_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int F = (WIDTH + 2 + PAR) * DIV;

   logic             clock = 1'b0;
   logic             input_reset_n = 1'b0;
   logic [WIDTH-1:0] input_data = '0;
   logic             input_start = 1'b0;
   logic             output_serial;
   logic             output_busy;
   logic             output_done;

   always #5 clock = ~clock;

   register_readback_tx #(.WIDTH(WIDTH), .DIV(DIV)) dut (
      .clock         (clock),
      .input_reset_n (input_reset_n),
      .input_data    (input_data),
      .input_start   (input_start),
      .output_serial (output_serial),
      .output_busy   (output_busy),
      .output_done   (output_done)
   );

   typedef struct {
      logic [WIDTH-1:0] data;
      int               done_cyc;
   } exp_t;

   exp_t q[$];
   logic samples[$];
   int   cyc   = 0;
   int   ready = 0;
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected line level for sample i of a frame carrying d.
   function automatic logic frame_bit(input logic [WIDTH-1:0] d, input int i);
      int slot;
      slot = i / DIV;
      if (slot == 0) return 1'b0;
      if (slot <= WIDTH) return d[slot-1];
      if (PAR == 1 && slot == WIDTH + 1) return ^d;
      return 1'b1;
   endfunction

   // Reference model: a start is accepted whenever the previous frame's done cycle has passed.
   always @(posedge clock) begin
      cyc++;
      if (!input_reset_n) begin
         q.delete();
         ready = 0;
      end else if (input_start && cyc >= ready) begin
         q.push_back('{input_data, cyc + F});
         ready = cyc + F + 1;
      end
   end

   // Monitor: gathers the line while busy and scores a frame on each done pulse.
   always @(negedge clock) begin
      exp_t        e;
      logic [63:0] act_v;
      logic [63:0] exp_v;
      if (!input_reset_n) begin
         samples.delete();
         check("reset_outputs", {61'd0, output_serial, output_busy, output_done}, 64'b100);
      end else begin
         if (output_busy) samples.push_back(output_serial);
         else check("idle_line", {63'd0, output_serial}, 64'd1);
         if (output_done) begin
            check("busy_clear_at_done", {63'd0, output_busy}, 64'd0);
            if (q.size() == 0) begin
               check("unexpected_done", 64'd1, 64'd0);
            end else begin
               e = q.pop_front();
               check("done_cycle", 64'(cyc), 64'(e.done_cyc));
               check("frame_length", 64'(samples.size()), 64'(F));
               act_v = '0;
               exp_v = '0;
               for (int i = 0; i < F; i++) begin
                  act_v[i] = (i < samples.size()) ? samples[i] : 1'bx;
                  exp_v[i] = frame_bit(e.data, i);
               end
               check("frame_bits", act_v, exp_v);
            end
            samples.delete();
         end
      end
   end

   // Inputs change at negedge or 1 ns after posedge, never at the sampling edge.
   task automatic send(input logic [WIDTH-1:0] d);
      input_data  = d;
      input_start = 1'b1;
      @(posedge clock);
      #1;
      input_start = 1'b0;
   endtask

   task automatic wait_ready();
      int guard = 0;
      @(negedge clock);
      while (cyc + 1 < ready && guard < 4 * F) begin
         @(negedge clock);
         guard++;
      end
   endtask

   initial begin
      // Reset held with start pulsing: outputs must stay idle.
      input_reset_n = 1'b0;
      repeat (2) @(negedge clock);
      input_data  = 8'h5A;
      input_start = 1'b1;
      repeat (3) @(negedge clock);
      input_start = 1'b0;
      @(posedge clock); #1;
      input_reset_n = 1'b1;
      repeat (5) @(negedge clock);

      // Directed frames.
      send(8'hA5); wait_ready();
      send(8'h07); wait_ready();

      // Start while busy is ignored.
      send(8'h3C);
      repeat (9) @(posedge clock);
      #1;
      input_data  = 8'hFF;
      input_start = 1'b1;
      @(posedge clock); #1;
      input_start = 1'b0;
      wait_ready();

      // Held start: back-to-back frames with data changing every cycle.
      input_start = 1'b1;
      for (int i = 0; i < 3 * F + 4; i++) begin
         input_data = WIDTH'($urandom);
         @(posedge clock); #1;
      end
      input_start = 1'b0;
      wait_ready();

      // Reset mid-DATA aborts immediately, then a fresh frame goes out.
      send(8'hC3);
      repeat (16) @(posedge clock);
      #1;
      input_reset_n = 1'b0;
      #1;
      check("abort_outputs", {61'd0, output_serial, output_busy, output_done}, 64'b100);
      repeat (3) @(posedge clock);
      #1;
      input_reset_n = 1'b1;
      @(negedge clock);
      send(8'h81); wait_ready();

      // Randomized frames with occasional ignored mid-frame starts.
      for (int n = 0; n < 30; n++) begin
         send(WIDTH'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, F - 6)) @(posedge clock);
            #1;
            input_data  = WIDTH'($urandom);
            input_start = 1'b1;
            @(posedge clock); #1;
            input_start = 1'b0;
         end
         wait_ready();
         repeat ($urandom_range(0, 3)) @(negedge clock);
      end

      for (int i = 0; i < 3 * F && q.size() != 0; i++) @(negedge clock);
      repeat (2) @(negedge clock);
      check("scoreboard_drained", 64'(q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
